des_decrypt_iter: RTL and testbench



---
 rtl/des_pkg.sv | 136 +++++++++++++
 rtl/des_decrypt_iter_if.sv | 20 ++
 rtl/DES_round.sv | 15 +
 rtl/des_dec_key_sched.sv | 40 ++++
 rtl/des_decrypt_iter.sv | 106 ++++++++++
 tb/tb_des_decrypt_iter.sv | 304 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/des_pkg.sv
// DES constant tables and bit-permutation helpers shared by the DES datapaths.
// Tables use FIPS 46 numbering: bit 1 is the MSB of the vector being permuted.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dec_state_e;

  localparam logic [4:0] LAST_ROUND = 5'd16;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Right-rotate amount applied before each decrypt round (round 1 first).
  localparam int SHIFT_DEC [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  // Left-rotate amount for the encrypt direction.
  localparam int SHIFT_ENC [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Indexed by {row[1:0], col[3:0]}.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  // FIPS bit n of a W-bit vector lives at Verilog index W-n.
  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[j])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_T[j])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_T[j])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[j])];
    return y;
  endfunction

  function automatic logic [47:0] e_perm(input logic [31:0] x);
    logic [47:0] y;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E_T[j])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P_T[j])];
    return y;
  endfunction

  function automatic logic [3:0] sbox_lookup(input logic [2:0] sel, input logic [5:0] six);
    return 4'(SBOX[sel][{six[5], six[0], six[4:1]}]);
  endfunction

  // Feistel f: expand, mix subkey, eight S-boxes (S1 feeds the top nibble), permute.
  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    x = e_perm(r) ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) s = {s[27:0], sbox_lookup(3'(b), 6'(x >> (42 - 6 * b)))};
    return p_perm(s);
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  // Rotation for decrypt round r (1..16); anything else means no rotation.
  function automatic logic [1:0] shift_dec_of(input logic [4:0] r);
    if (r == 5'd0 || r > LAST_ROUND) return 2'd0;
    return 2'(SHIFT_DEC[4'(r - 5'd1)]);
  endfunction

endpackage

// File: rtl/des_decrypt_iter_if.sv
// Block-stream interface: ciphertext+key in, plaintext out, valid/ready on both sides.
interface des_decrypt_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/DES_round.sv
// One combinational DES Feistel round on the packed block: L in the low word, R in the high word.
module DES_round
  import des_pkg::*;
(
  input  logic [63:0] blk_i,
  input  logic [47:0] subkey_i,
  output logic [63:0] blk_o
);

  // New L = old R; new R = old L ^ f(old R, K).
  always_comb begin
    blk_o = {blk_i[31:0] ^ des_f(blk_i[63:32], subkey_i), blk_i[63:32]};
  end

endmodule

// File: rtl/des_dec_key_sched.sv
// Reverse DES key schedule: holds {C,D}, right-rotates per decrypt round and emits PC2 of the
// rotated value, so the subkey for round r is available combinationally during that round.
module des_dec_key_sched
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [63:0] key_i,
  input  logic        step_i,
  input  logic [4:0]  rnd_i,
  output logic [47:0] subkey_o
);

  logic [55:0] cd_q;
  logic [55:0] cd_d;
  logic [55:0] cd_rot;
  logic [1:0]  shamt;

  // Rotate C and D independently for the current round, then select the subkey bits.
  always_comb begin
    shamt    = shift_dec_of(rnd_i);
    cd_rot   = {rotr28(cd_q[55:28], shamt), rotr28(cd_q[27:0], shamt)};
    subkey_o = pc2_perm(cd_rot);
  end

  // A new key replaces the schedule; otherwise each round keeps its rotated value.
  always_comb begin
    cd_d = cd_q;
    if (load_i)      cd_d = pc1_perm(key_i);
    else if (step_i) cd_d = cd_rot;
  end

  // {C,D} register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cd_q <= '0;
    else        cd_q <= cd_d;
  end

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption: IP on accept, 16 rounds with K16..K1, FP wired straight from state.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a block, in_ready=1
//   RUN     | one Feistel round per clock, rnd 1..16, in_ready=0
//   DONE    | plaintext on out_data, out_valid=1, in_ready follows out_ready
module des_decrypt_iter
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  des_decrypt_iter_if.slave bus
);

  dec_state_e  state_q, state_d;
  logic [4:0]  rnd_q, rnd_d;
  logic [63:0] blk_q, blk_d;
  logic [63:0] blk_rnd;
  logic [63:0] ip_in;
  logic [47:0] subkey;
  logic        accept;
  logic        step;

  // The state register holds R16 in the high word and L16 in the low word once done,
  // which is already the R16L16 preoutput, so FP applies to it directly.
  assign bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_data  = fp_perm(blk_q);
  assign accept        = bus.in_valid && bus.in_ready;
  assign step          = (state_q == ST_RUN);

  des_dec_key_sched u_key_sched (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .key_i    (bus.in_key),
    .step_i   (step),
    .rnd_i    (rnd_q),
    .subkey_o (subkey)
  );

  DES_round u_round (
    .blk_i    (blk_q),
    .subkey_i (subkey),
    .blk_o    (blk_rnd)
  );

  // Next state and round counter.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_RUN;
          rnd_d   = 5'd1;
        end
      end
      ST_RUN: begin
        if (rnd_q == LAST_ROUND) begin
          state_d = ST_DONE;
          rnd_d   = 5'd0;
        end else begin
          rnd_d = rnd_q + 5'd1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            state_d = ST_RUN;
            rnd_d   = 5'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        rnd_d   = 5'd0;
      end
    endcase
  end

  // Block datapath: load IP(ciphertext) with L0 in the low word, or advance one round.
  always_comb begin
    ip_in = ip_perm(bus.in_data);
    blk_d = blk_q;
    if (accept)    blk_d = {ip_in[31:0], ip_in[63:32]};
    else if (step) blk_d = blk_rnd;
  end

  // State, round counter and block registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rnd_q   <= 5'd0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
    end
  end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Bench for des_decrypt_iter: known-answer table, handshake corner cases, and random
// round-trips against a straightforward DES model with a forward key schedule.
module tb_des_decrypt_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_decrypt_iter_if bus ();

  des_decrypt_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  int t_ip[$]  = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                   57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  int t_fp[$]  = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                   36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  int t_pc1[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                   63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int t_pc2[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int t_e[$]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                   16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  int t_p[$]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int t_sh[$]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int t_sb[$]  = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // Output bit j (1 = MSB of an n-bit result) takes input bit t[j-1] of an m-bit value.
  function automatic logic [63:0] perm(input int t[$], input int m, input logic [63:0] x);
    logic [63:0] y = '0;
    int n = t.size();
    for (int j = 1; j <= n; j++) y[n - j] = x[m - t[j - 1]];
    return y;
  endfunction

  function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s = '0;
    int v, row, col;
    e = 48'(perm(t_e, 32, {32'h0, r})) ^ k;
    for (int b = 0; b < 8; b++) begin
      v   = int'((e >> (42 - 6 * b)) & 48'h3f);
      row = ((v >> 4) & 2) | (v & 1);
      col = (v >> 1) & 15;
      s   = (s << 4) | 32'(t_sb[b * 64 + row * 16 + col]);
    end
    return 32'(perm(t_p, 32, {32'h0, s}));
  endfunction

  // Classic DES: all sixteen subkeys by left rotation, used forward (encrypt) or reversed.
  function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] blk, input bit dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [63:0] x;
    logic [31:0] l, r, t;
    cd = 56'(perm(t_pc1, 64, key));
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < t_sh[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[i] = 48'(perm(t_pc2, 56, {8'h0, c, d}));
    end
    x = perm(t_ip, 64, blk);
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_model(r, dec ? ks[15 - i] : ks[i]);
      l = t;
    end
    return perm(t_fp, 64, {r, l});
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Offer one block to an idle engine and retire it. poke_at >= 0 re-offers junk at that
  // round offset (rnd = poke_at+1) to show RUN ignores in_valid. lat counts edges after accept.
  task automatic run_block(input logic [63:0] key, input logic [63:0] ct, input int poke_at,
                           output logic [63:0] pt, output int lat);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = ct;
    bus.in_key    = key;
    bus.out_ready = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      bus.in_data = {$urandom, $urandom};
      bus.in_key  = {$urandom, $urandom};
      if (lat == poke_at) begin
        bus.in_valid = 1'b1;
        #1 chk("run_in_ready", 64'(bus.in_ready), 64'd0);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.in_valid  = 1'b0;
    pt            = bus.out_data;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [63:0] key;
    logic [63:0] ct;
    logic [63:0] pt;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [63:0] pt, d1, d2, held, kd, rpt, rkey, rct;
    int lat, pulses, first, second, seen;

    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] pt, d1, d2, held, kd, rpt, rkey, rct;
    int lat, pulses, first, second, seen;

    vecs[0] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF};
    vecs[1] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787};
    vecs[2] = '{64'h0000000000000000, 64'h8CA64DE9C1B123A7, 64'h0000000000000000};
    vecs[3] = '{64'h0101010101010101, 64'h8CA64DE9C1B123A7, 64'h0000000000000000};
    vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF};
    vecs[5] = '{64'h123556789ABDDEF0, 64'h85E813540F0AB405, 64'h0123456789ABCDEF};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_data", bus.out_data, 64'd0);
    rst_n = 1'b1;

    // known-answer table
    for (int i = 0; i < 6; i++) begin
      chk("model_kat", des_model(vecs[i].key, vecs[i].ct, 1'b1), vecs[i].pt);
      run_block(vecs[i].key, vecs[i].ct, -1, pt, lat);
      chk("kat_pt", pt, vecs[i].pt);
      chk("kat_latency", 64'(lat), 64'd16);
      chk("kat_retired", 64'(bus.out_valid), 64'd0);
    end

    // back-to-back with out_ready high and in_valid held
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = vecs[0].ct;
    bus.in_key    = vecs[0].key;
    @(negedge clk);
    bus.in_data = vecs[1].ct;
    bus.in_key  = vecs[1].key;
    pulses = 0;
    first  = -1;
    second = -1;
    d1 = '0;
    d2 = '0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.out_valid) begin
        pulses++;
        if (pulses == 1) begin
          first = c;
          d1 = bus.out_data;
          chk("b2b_in_ready_done", 64'(bus.in_ready), 64'd1);
        end else if (pulses == 2) begin
          second = c;
          d2 = bus.out_data;
        end
      end
      if (first >= 0 && c == first + 1) bus.in_valid = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_first_at", 64'(first), 64'd16);
    chk("b2b_spacing", 64'(second - first), 64'd17);
    chk("b2b_first_pt", d1, vecs[0].pt);
    chk("b2b_second_pt", d2, vecs[1].pt);
    chk("b2b_pulses", 64'(pulses), 64'd2);

    // backpressure in DONE
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = vecs[4].ct;
    bus.in_key   = vecs[4].key;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 64'(lat), 64'd16);
    held = bus.out_data;
    bus.in_valid = 1'b1;
    bus.in_data  = vecs[0].ct;
    bus.in_key   = vecs[0].key;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_out_data", bus.out_data, held);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    chk("bp_pt", held, vecs[4].pt);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      seen += int'(bus.out_valid);
      @(negedge clk);
    end
    chk("bp_single_transfer", 64'(seen), 64'd0);
    chk("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);

    // junk offered mid-RUN at rnd=8 is ignored
    run_block(vecs[0].key, vecs[0].ct, 7, pt, lat);
    chk("run_poke_pt", pt, vecs[0].pt);
    chk("run_poke_latency", 64'(lat), 64'd16);

    // reset at rnd=10
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = vecs[1].ct;
    bus.in_key   = vecs[1].key;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_out_data", bus.out_data, 64'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      seen += int'(bus.out_valid);
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      seen += int'(bus.out_valid);
    end
    chk("midrst_no_pulse", 64'(seen), 64'd0);
    chk("midrst_in_ready_after", 64'(bus.in_ready), 64'd1);
    run_block(vecs[0].key, vecs[0].ct, -1, pt, lat);
    chk("midrst_next_pt", pt, vecs[0].pt);

    // random round-trips; odd iterations flip random parity bits of the key
    for (int i = 0; i < 1000; i++) begin
      rpt  = {$urandom, $urandom};
      rkey = {$urandom, $urandom};
      rct  = des_model(rkey, rpt, 1'b0);
      kd   = rkey;
      if (i % 2 == 1) kd = rkey ^ ({$urandom, $urandom} & 64'h0101010101010101);
      run_block(kd, rct, -1, pt, lat);
      chk("rand_roundtrip", pt, rpt);
      if (i < 4) chk("rand_latency", 64'(lat), 64'd16);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
